// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage for the RV32I core. This block:
//   - owns the program counter;
//   - drives the combinational instruction ROM address;
//   - captures the returned word into the IF/ID pipeline register.
// Stall, flush and taken-branch/jump redirect come from downstream stages.
// A run of ZERO_LIMIT consecutive all-zero words (unprogrammed ROM) parks
// fetch in HALT until the next redirect.
//
// Parameters:
//   RESET_PC    PC value loaded on reset
//   ZERO_LIMIT  consecutive accepted zero words that trigger HALT (1..15)
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous, active-high reset
//   stall        hold PC and IF/ID
//   flush        squash the word being captured into IF/ID
//   redirect     taken branch/jump: load PC from redirect_pc
//   redirect_pc  redirect target, bits [1:0] ignored
//   imem_addr    ROM address (combinational copy of PC)
//   imem_data    ROM read data, valid in the same cycle as imem_addr
//   ifid_pc      PC of the captured instruction
//   ifid_pc4     ifid_pc + 4, mod 2^32
//   ifid_instr   captured instruction, NOP (addi x0,x0,0) when bubble
//   ifid_valid   IF/ID holds a real instruction
//   halted       fetch is in HALT
// ---------------------------------------------------------------------------
module fetch_stage #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned ZERO_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        flush,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   output logic [31:0] ifid_pc,
   output logic [31:0] ifid_pc4,
   output logic [31:0] ifid_instr,
   output logic        ifid_valid,
   output logic        halted
);

   localparam logic [31:0] NOP   = 32'h0000_0013;
   localparam logic [3:0]  ZLAST = 4'(ZERO_LIMIT - 1);

   typedef enum logic {RUN, HALT} state_t;
   typedef enum logic [1:0] {IF_HOLD, IF_BUBBLE, IF_LOAD} ifop_t;

   state_t      state, state_nx;
   ifop_t       ifop;
   logic [31:0] pc_p0, pc_nx, pc_plus4;
   logic [3:0]  zcnt, zcnt_nx;
   logic        word_zero;

   // An all-zero word is not a legal instruction; it is delivered as a NOP
   function automatic logic [31:0] fetch_word(input logic [31:0] w);
      return (w == 32'h0) ? NOP : w;
   endfunction

   assign pc_plus4  = pc_p0 + 32'd4;
   assign word_zero = (imem_data == 32'h0);
   assign imem_addr = pc_p0;
   assign halted    = (state == HALT);

   always_comb begin
      state_nx = state;
      pc_nx    = pc_p0;
      zcnt_nx  = zcnt;
      ifop     = IF_HOLD;
      if (redirect) begin
         // Masking keeps pc word-aligned; redirect wins from RUN and HALT
         pc_nx    = redirect_pc & ~32'h3;
         ifop     = IF_BUBBLE;
         zcnt_nx  = 4'd0;
         state_nx = RUN;
      end else if (state == RUN) begin
         if (stall) begin
            if (flush) ifop = IF_BUBBLE;
         end else if (flush) begin
            pc_nx = pc_plus4;
            ifop  = IF_BUBBLE;
         end else if (word_zero && (zcnt == ZLAST)) begin
            // Last zero of the run: park on this pc with an empty IF/ID
            state_nx = HALT;
            ifop     = IF_BUBBLE;
            zcnt_nx  = 4'd0;
         end else begin
            pc_nx   = pc_plus4;
            ifop    = IF_LOAD;
            zcnt_nx = word_zero ? (zcnt + 4'd1) : 4'd0;
         end
      end
   end

   // Stage 0: program counter, zero-run counter and fetch state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_p0 <= RESET_PC;
         zcnt  <= 4'd0;
         state <= RUN;
      end else begin
         pc_p0 <= pc_nx;
         zcnt  <= zcnt_nx;
         state <= state_nx;
      end
   end

   // Stage 1: IF/ID pipeline register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ifid_pc    <= 32'h0;
         ifid_pc4   <= 32'h0;
         ifid_instr <= NOP;
         ifid_valid <= 1'b0;
      end else begin
         case (ifop)
            IF_BUBBLE: begin
               ifid_pc    <= 32'h0;
               ifid_pc4   <= 32'h0;
               ifid_instr <= NOP;
               ifid_valid <= 1'b0;
            end
            IF_LOAD: begin
               ifid_pc    <= pc_p0;
               ifid_pc4   <= pc_plus4;
               ifid_instr <= fetch_word(imem_data);
               ifid_valid <= ~word_zero;
            end
            default: ;
         endcase
      end
   end

endmodule
